// File: rtl/pipe_ctrl.sv
// Pipeline control unit.
// Drives the stall vector that freezes the PC and the pipeline registers.
// Arbitrates stall requests and owns the EX multi-cycle sequencer.
// Also owns the flush/redirect path, a stuck-stall watchdog and the
// performance counters.
// Stall bits: [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB, 1 = hold.
module pipe_ctrl #(
    parameter int MC_CNT_W   = 6,
    parameter int WDOG_LIMIT = 1023,
    parameter int WDOG_W     = 10,
    parameter int PERF_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_if,
    input  logic                stallreq_id,
    input  logic                stallreq_mem,
    input  logic                mc_start,
    input  logic [MC_CNT_W-1:0] mc_cycles,
    input  logic                flush_req,
    input  logic [31:0]         flush_pc,
    input  logic                perf_clr,
    output logic [5:0]          stall,
    output logic                flush,
    output logic [31:0]         new_pc,
    output logic                mc_busy,
    output logic                wdog_fire,
    output logic [PERF_W-1:0]   perf_stall_cnt,
    output logic [PERF_W-1:0]   perf_bubble_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mc_state_t;

    mc_state_t             state_r;
    mc_state_t             state_nxt_s;
    logic [MC_CNT_W-1:0]   cnt_r;
    logic [MC_CNT_W-1:0]   cnt_nxt_s;
    logic                  stallreq_ex_s;
    logic [5:0]            stall_s;
    logic                  flush_s;
    logic [31:0]           new_pc_s;
    logic                  stalled_s;
    logic [WDOG_W-1:0]     wcnt_r;
    logic                  wdog_fire_r;
    logic [PERF_W-1:0]     perf_stall_r;
    logic [PERF_W-1:0]     perf_bubble_r;

    // EX stall request: raised in the start cycle itself and throughout BUSY
    assign stallreq_ex_s = ((state_r == ST_IDLE) && mc_start && (mc_cycles != {MC_CNT_W{1'b0}}))
                         || (state_r == ST_BUSY);

    // Multi-cycle sequencer state and remaining-cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {MC_CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Sequencer next state; a flush abandons any op in flight
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (flush_req) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = {MC_CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // A one-cycle op is covered by the start-cycle stall alone
                    if (mc_start && (mc_cycles >= MC_CNT_W'(2))) begin
                        state_nxt_s = ST_BUSY;
                        cnt_nxt_s   = mc_cycles - MC_CNT_W'(1);
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // Keeps counting even while a MEM stall dominates the vector
                    cnt_nxt_s = cnt_r - MC_CNT_W'(1);
                    if (cnt_r == MC_CNT_W'(1)) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {MC_CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Priority arbitration: flush > mem > ex > id > if; all quiet during reset
    always_comb begin
        stall_s  = 6'b000000;
        flush_s  = 1'b0;
        new_pc_s = 32'h0000_0000;
        if (rst) begin
            stall_s = 6'b000000;
        end else if (flush_req) begin
            flush_s  = 1'b1;
            new_pc_s = flush_pc;
        end else if (stallreq_mem) begin
            stall_s = 6'b011111;
        end else if (stallreq_ex_s) begin
            stall_s = 6'b001111;
        end else if (stallreq_id) begin
            stall_s = 6'b000111;
        end else if (stallreq_if) begin
            stall_s = 6'b000011;
        end else begin
            stall_s = 6'b000000;
        end
    end

    assign stalled_s = stall_s[0] & ~flush_s;

    // Watchdog: count consecutive stalled cycles, pulse once per WDOG_LIMIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_r      <= {WDOG_W{1'b0}};
            wdog_fire_r <= 1'b0;
        end else if (stalled_s) begin
            if (wcnt_r == WDOG_W'(WDOG_LIMIT - 1)) begin
                wcnt_r      <= {WDOG_W{1'b0}};
                wdog_fire_r <= 1'b1;
            end else begin
                wcnt_r      <= wcnt_r + WDOG_W'(1);
                wdog_fire_r <= 1'b0;
            end
        end else begin
            wcnt_r      <= {WDOG_W{1'b0}};
            wdog_fire_r <= 1'b0;
        end
    end

    // Saturating performance counters; clear wins over a same-cycle count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_r  <= {PERF_W{1'b0}};
            perf_bubble_r <= {PERF_W{1'b0}};
        end else if (perf_clr) begin
            perf_stall_r  <= {PERF_W{1'b0}};
            perf_bubble_r <= {PERF_W{1'b0}};
        end else begin
            if (stall_s[0] && (perf_stall_r != {PERF_W{1'b1}})) begin
                perf_stall_r <= perf_stall_r + PERF_W'(1);
            end
            if (stall_s[2] && !stall_s[3] && (perf_bubble_r != {PERF_W{1'b1}})) begin
                perf_bubble_r <= perf_bubble_r + PERF_W'(1);
            end
        end
    end

    assign stall           = stall_s;
    assign flush           = flush_s;
    assign new_pc          = new_pc_s;
    assign mc_busy         = (state_r == ST_BUSY);
    assign wdog_fire       = wdog_fire_r;
    assign perf_stall_cnt  = perf_stall_r;
    assign perf_bubble_cnt = perf_bubble_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver pushes model predictions, the monitor pops and compares.
module tb_pipe_ctrl;

    localparam int LIM  = 4;
    localparam int PW   = 4;
    localparam int PMAX = (1 << PW) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_mem, mc_start, flush_req, perf_clr;
    logic [5:0]  mc_cycles;
    logic [31:0] flush_pc;
    logic [5:0]  stall;
    logic        flush, mc_busy, wdog_fire;
    logic [31:0] new_pc;
    logic [PW-1:0] perf_stall_cnt, perf_bubble_cnt;

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        busy;
        logic        fire;
        logic [3:0]  ps;
        logic [3:0]  pb;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // reference model state
    int   ex_rem;   // EX stall cycles still owed after the current one
    int   run;      // consecutive stalled, unflushed cycles
    bit   m_fire;
    int   m_ps, m_pb;

    pipe_ctrl #(.MC_CNT_W(6), .WDOG_LIMIT(LIM), .WDOG_W(3), .PERF_W(PW)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id), .stallreq_mem(stallreq_mem),
        .mc_start(mc_start), .mc_cycles(mc_cycles),
        .flush_req(flush_req), .flush_pc(flush_pc), .perf_clr(perf_clr),
        .stall(stall), .flush(flush), .new_pc(new_pc), .mc_busy(mc_busy),
        .wdog_fire(wdog_fire), .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        ex_rem = 0; run = 0; m_fire = 1'b0; m_ps = 0; m_pb = 0;
    endtask

    task automatic idle_inputs();
        stallreq_if = 1'b0; stallreq_id = 1'b0; stallreq_mem = 1'b0;
        mc_start = 1'b0; mc_cycles = 6'd0; flush_req = 1'b0; flush_pc = 32'h0; perf_clr = 1'b0;
    endtask

    // one cycle of stimulus plus the model's prediction for that cycle
    task automatic step(input logic s_if, input logic s_id, input logic s_mem,
                        input logic start, input logic [5:0] ncyc,
                        input logic fl, input logic [31:0] pc, input logic clr);
        exp_t e;
        logic [5:0] sv;
        bit ex_req;
        @(posedge clk); #1;
        stallreq_if = s_if; stallreq_id = s_id; stallreq_mem = s_mem;
        mc_start = start; mc_cycles = ncyc; flush_req = fl; flush_pc = pc; perf_clr = clr;

        ex_req = (ex_rem > 0) || (start && ncyc != 6'd0);
        if (fl)          sv = 6'b000000;
        else if (s_mem)  sv = 6'b011111;
        else if (ex_req) sv = 6'b001111;
        else if (s_id)   sv = 6'b000111;
        else if (s_if)   sv = 6'b000011;
        else             sv = 6'b000000;

        e.stall = sv;
        e.flush = fl;
        e.pc    = fl ? pc : 32'h0;
        e.busy  = (ex_rem > 0);
        e.fire  = m_fire;
        e.ps    = 4'(m_ps);
        e.pb    = 4'(m_pb);
        q.push_back(e);

        // advance model to the next edge
        if (sv[0] && !fl) begin
            run    = run + 1;
            m_fire = (run % LIM) == 0;
        end else begin
            run    = 0;
            m_fire = 1'b0;
        end
        if (clr) begin
            m_ps = 0; m_pb = 0;
        end else begin
            if (sv[0] && m_ps < PMAX) m_ps++;
            if (sv[2] && !sv[3] && m_pb < PMAX) m_pb++;
        end
        if (fl)                           ex_rem = 0;
        else if (ex_rem > 0)              ex_rem = ex_rem - 1;
        else if (start && ncyc >= 6'd2)   ex_rem = int'(ncyc) - 1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_stall"}, {26'h0, stall}, 32'h0);
        chk({tag, "_flush"}, {31'h0, flush}, 32'h0);
        chk({tag, "_newpc"}, new_pc, 32'h0);
        chk({tag, "_busy"},  {31'h0, mc_busy}, 32'h0);
        chk({tag, "_fire"},  {31'h0, wdog_fire}, 32'h0);
        chk({tag, "_pstall"}, {28'h0, perf_stall_cnt}, 32'h0);
        chk({tag, "_pbub"},  {28'h0, perf_bubble_cnt}, 32'h0);
    endtask

    // asynchronous reset in the middle of a cycle, released one edge later
    task automatic reset_mid();
        #6;
        idle_inputs();
        rst = 1'b1;
        #1;
        chk_zero("rst_mid");
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // monitor: every cycle that has a prediction, compare all outputs
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("stall",  {26'h0, stall}, {26'h0, e.stall});
            chk("flush",  {31'h0, flush}, {31'h0, e.flush});
            chk("new_pc", new_pc, e.pc);
            chk("mc_busy", {31'h0, mc_busy}, {31'h0, e.busy});
            chk("wdog_fire", {31'h0, wdog_fire}, {31'h0, e.fire});
            chk("perf_stall", {28'h0, perf_stall_cnt}, {28'h0, e.ps});
            chk("perf_bubble", {28'h0, perf_bubble_cnt}, {28'h0, e.pb});
        end
    end

    initial begin
        int wait_cnt;
        idle_inputs();
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst_init");
        rst = 1'b0;

        // multi-cycle op of 5: stall cycles 0..4, busy 1..4
        step(0, 0, 0, 1, 6'd5, 0, 32'h0, 0);
        repeat (6) step(0, 0, 0, 0, 6'd0, 0, 32'h0, 0);

        // reset while busy on an 8-cycle op
        step(0, 0, 0, 1, 6'd8, 0, 32'h0, 0);
        repeat (2) step(0, 0, 0, 0, 6'd0, 0, 32'h0, 0);
        reset_mid();
        repeat (2) step(0, 0, 0, 0, 6'd0, 0, 32'h0, 0);

        // single-cycle and zero-cycle ops
        step(0, 0, 0, 1, 6'd1, 0, 32'h0, 0);
        step(0, 0, 0, 1, 6'd0, 0, 32'h0, 0);
        step(0, 0, 0, 0, 6'd0, 0, 32'h0, 0);

        // load-use bubble, then bubble masked by a MEM stall
        step(0, 1, 0, 0, 6'd0, 0, 32'h0, 0);
        step(0, 0, 0, 0, 6'd0, 0, 32'h0, 0);
        step(0, 1, 1, 0, 6'd0, 0, 32'h0, 0);
        step(0, 0, 0, 0, 6'd0, 0, 32'h0, 0);

        // flush during busy
        step(0, 0, 0, 1, 6'd6, 0, 32'h0, 0);
        step(0, 0, 0, 0, 6'd0, 0, 32'h0, 0);
        step(0, 0, 0, 1, 6'd3, 1, 32'hBFC0_0380, 0);
        repeat (2) step(0, 0, 0, 0, 6'd0, 0, 32'h0, 0);

        // MEM stall overlapping a busy op
        step(0, 0, 0, 1, 6'd4, 0, 32'h0, 0);
        repeat (2) step(0, 0, 1, 0, 6'd0, 0, 32'h0, 0);
        repeat (3) step(0, 0, 0, 0, 6'd0, 0, 32'h0, 0);

        // watchdog with a held IF stall, then perf saturation and clear
        repeat (10) step(1, 0, 0, 0, 6'd0, 0, 32'h0, 0);
        step(0, 0, 0, 0, 6'd0, 0, 32'h0, 0);
        repeat (20) step(1, 0, 0, 0, 6'd0, 0, 32'h0, 0);
        step(1, 0, 0, 0, 6'd0, 0, 32'h0, 1);
        repeat (2) step(0, 0, 0, 0, 6'd0, 0, 32'h0, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) < 30, $urandom_range(99) < 20, $urandom_range(99) < 12,
                 $urandom_range(99) < 20, 6'($urandom_range(9)),
                 $urandom_range(99) < 5, $urandom, $urandom_range(99) < 3);
            if ($urandom_range(999) == 0) reset_mid();
        end

        // drain the scoreboard with a bounded wait
        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        tests++;
        if (q.size() > 0) begin
            fails++;
            $display("FAIL drain act=%0d pending exp=0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
